// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two-requester round-robin
// sequencer in front of one shared comb ALU.
module alu_share_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic [DATA_WIDTH-1:0]    req0_srca,
  input  logic [DATA_WIDTH-1:0]    req0_srcb,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  input  logic [DATA_WIDTH-1:0]    req1_srca,
  input  logic [DATA_WIDTH-1:0]    req1_srcb,
  output logic                     rsp0_valid,
  input  logic                     rsp0_ready,
  output logic [DATA_WIDTH-1:0]    rsp0_result,
  output logic                     rsp0_err,
  output logic                     rsp1_valid,
  input  logic                     rsp1_ready,
  output logic [DATA_WIDTH-1:0]    rsp1_result,
  output logic                     rsp1_err,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_operation,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic prio, prio_nxt;
  logic owner, owner_nxt;
  logic err_q, err_nxt;

  logic [OPCODE_LENGTH-1:0] op_q, op_nxt;
  logic [DATA_WIDTH-1:0]    srca_q, srca_nxt;
  logic [DATA_WIDTH-1:0]    srcb_q, srcb_nxt;
  logic [DATA_WIDTH-1:0]    res_q, res_nxt;

  logic any_v;
  logic gnt;
  logic rsp_hs;

  logic [OPCODE_LENGTH-1:0] sel_op;
  logic [DATA_WIDTH-1:0]    sel_a;
  logic [DATA_WIDTH-1:0]    sel_b;

  // Codes the shared ALU actually implements;
  // anything else still runs but is flagged.
  function automatic logic op_ok(
    input logic [OPCODE_LENGTH-1:0] op
  );
    return op inside {
      OPCODE_LENGTH'(4'h0),
      OPCODE_LENGTH'(4'h1),
      OPCODE_LENGTH'(4'h2),
      OPCODE_LENGTH'(4'h3),
      OPCODE_LENGTH'(4'h4),
      OPCODE_LENGTH'(4'h5),
      OPCODE_LENGTH'(4'h8)
    };
  endfunction

  assign any_v = req0_valid | req1_valid;

  // Grant: lone requester wins, ties go to prio.
  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      req0_valid & req1_valid:  gnt = prio;
      ~req0_valid & req1_valid: gnt = 1'b1;
      default:                  gnt = 1'b0;
    endcase
  end

  assign sel_op = gnt ? req1_op   : req0_op;
  assign sel_a  = gnt ? req1_srca : req0_srca;
  assign sel_b  = gnt ? req1_srcb : req0_srcb;

  assign rsp_hs = owner ? rsp1_ready : rsp0_ready;

  // Next state, captured fields and handshakes.
  always_comb begin
    state_nxt  = state;
    prio_nxt   = prio;
    owner_nxt  = owner;
    err_nxt    = err_q;
    op_nxt     = op_q;
    srca_nxt   = srca_q;
    srcb_nxt   = srcb_q;
    res_nxt    = res_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req0_ready = any_v & ~gnt;
        req1_ready = any_v & gnt;
        if (any_v) begin
          owner_nxt = gnt;
          op_nxt    = sel_op;
          srca_nxt  = sel_a;
          srcb_nxt  = sel_b;
          err_nxt   = ~op_ok(sel_op);
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        res_nxt   = alu_result;
        state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        if (rsp_hs) begin
          prio_nxt  = ~owner;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset drops any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      prio   <= 1'b0;
      owner  <= 1'b0;
      err_q  <= 1'b0;
      op_q   <= '0;
      srca_q <= '0;
      srcb_q <= '0;
      res_q  <= '0;
    end else begin
      state  <= state_nxt;
      prio   <= prio_nxt;
      owner  <= owner_nxt;
      err_q  <= err_nxt;
      op_q   <= op_nxt;
      srca_q <= srca_nxt;
      srcb_q <= srcb_nxt;
      res_q  <= res_nxt;
    end
  end

  assign alu_operation = op_q;
  assign alu_srca      = srca_q;
  assign alu_srcb      = srcb_q;

  assign rsp0_result = res_q;
  assign rsp1_result = res_q;
  assign rsp0_err    = err_q;
  assign rsp1_err    = err_q;

  assign busy = (state != IDLE);

endmodule
